twos_comp_deser: RTL and testbench

Serial-to-parallel collector sitting directly downstream of the serial two's-complement stage. It samples the complementer's LSB-first output bit stream, frames it into WIDTH-bit words using a start marker, and presents each completed word on a single-entry valid/ready parallel port. Overrun and broken-frame conditions are flagged so the consumer can detect lost or corrupted data.

---
 rtl/tc_pkg.sv | 17 +
 rtl/deser_out_reg.sv | 36 +++
 rtl/twos_comp_deser.sv | 95 +++++++++
 tb/tb_twos_comp_deser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tc_pkg.sv
// Shared definitions for the serial two's-complement deserializer: FSM states,
// default word width and the bit-count width helper.
package tc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold values 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/deser_out_reg.sv
// Single-entry valid/ready holding register for completed words; a word that
// arrives while the entry is full and not draining is dropped and flagged.
module deser_out_reg
    import tc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             p_ready,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    output logic             ovf
);

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            p_data  <= '0;
            p_valid <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            // A same-edge drain frees the entry, so the new word replaces the old one.
            if (!p_valid || p_ready) begin
                p_data  <= load_data;
                p_valid <= 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end else if (p_valid && p_ready) begin
            p_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/twos_comp_deser.sv
// Frames the complementer's LSB-first bit stream into WIDTH-bit words using a
// start marker and hands each word to a single-entry output register.
module twos_comp_deser
    import tc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             s_valid,
    input  logic             s_start,
    input  logic             s_bit,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             ovf,
    output logic             ferr
);

    localparam int CNT_W = cnt_w(WIDTH);

    deser_state_t     state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt, shifted;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ferr_nxt;
    logic             done;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            ferr  <= 1'b0;
        end else begin
            state <= state_nxt;
            sr    <= sr_nxt;
            cnt   <= cnt_nxt;
            ferr  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        cnt_nxt   = cnt;
        ferr_nxt  = 1'b0;
        done      = 1'b0;
        shifted   = {s_bit, sr[WIDTH-1:1]};
        if (s_valid) begin
            case (state)
                IDLE: begin
                    if (s_start) begin
                        sr_nxt    = {s_bit, {(WIDTH-1){1'b0}}};
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    // A start marker wins over completion: the partial word is abandoned.
                    if (s_start) begin
                        sr_nxt   = {s_bit, {(WIDTH-1){1'b0}}};
                        cnt_nxt  = CNT_W'(1);
                        ferr_nxt = 1'b1;
                    end else if (cnt == CNT_W'(WIDTH - 1)) begin
                        sr_nxt    = shifted;
                        cnt_nxt   = '0;
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        sr_nxt  = shifted;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);

    deser_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .r_n      (r_n),
        .load     (done),
        .load_data(shifted),
        .p_ready  (p_ready),
        .p_data   (p_data),
        .p_valid  (p_valid),
        .ovf      (ovf)
    );

endmodule

// File: tb/tb_twos_comp_deser.sv
// Self-checking bench: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based behavioural model of framing and the output slot.
module tb_twos_comp_deser;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             r_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_start = 1'b0;
    logic             s_bit = 1'b0;
    logic             p_ready = 1'b0;
    logic [WIDTH-1:0] p_data;
    logic             p_valid;
    logic             busy;
    logic             ovf;
    logic             ferr;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model state
    bit          m_bits[$];
    bit          m_in_frame = 1'b0;
    logic [31:0] m_data = '0;
    bit          m_valid = 1'b0;
    bit          m_ovf = 1'b0;
    bit          m_ferr = 1'b0;

    twos_comp_deser #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .r_n    (r_n),
        .s_valid(s_valid),
        .s_start(s_start),
        .s_bit  (s_bit),
        .p_data (p_data),
        .p_valid(p_valid),
        .p_ready(p_ready),
        .busy   (busy),
        .ovf    (ovf),
        .ferr   (ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_in_frame = 1'b0;
        m_data = '0;
        m_valid = 1'b0;
        m_ovf = 1'b0;
        m_ferr = 1'b0;
    endtask

    task automatic model_edge(input bit v, input bit st, input bit b, input bit rdy);
        logic [31:0] word;
        bit          complete;
        complete = 1'b0;
        word = '0;
        m_ferr = 1'b0;
        if (v) begin
            if (st) begin
                if (m_in_frame) m_ferr = 1'b1;
                m_bits.delete();
                m_bits.push_back(b);
                m_in_frame = 1'b1;
            end else if (m_in_frame) begin
                m_bits.push_back(b);
            end
            if (m_in_frame && m_bits.size() == WIDTH) begin
                for (int k = 0; k < WIDTH; k++) word = word + (32'(m_bits[k]) << k);
                complete = 1'b1;
                m_bits.delete();
                m_in_frame = 1'b0;
            end
        end
        if (complete) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data = word;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("p_data", 32'(p_data), m_data);
        chk("p_valid", 32'(p_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_in_frame));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("ferr", 32'(ferr), 32'(m_ferr));
    endtask

    task automatic cyc(input bit v, input bit st, input bit b, input bit rdy);
        @(negedge clk);
        s_valid = v;
        s_start = st;
        s_bit   = b;
        p_ready = rdy;
        @(posedge clk);
        model_edge(v, st, b, rdy);
        #1;
        check_all();
    endtask

    task automatic send_word(input logic [7:0] w, input bit rdy, input bit rdy_last);
        for (int k = 0; k < WIDTH; k++)
            cyc(1'b1, k == 0, w[k], (k == WIDTH - 1) ? rdy_last : rdy);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        r_n = 1'b0;
        #1;
        chk({tag, "_p_data"}, 32'(p_data), 32'd0);
        chk({tag, "_p_valid"}, 32'(p_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
        chk({tag, "_ferr"}, 32'(ferr), 32'd0);
        model_reset();
        s_valid = 1'b0;
        s_start = 1'b0;
        @(negedge clk);
        r_n = 1'b1;
    endtask

    initial begin
        logic [7:0] w;
        #1;
        chk("rst_p_data", 32'(p_data), 32'd0);
        chk("rst_p_valid", 32'(p_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        repeat (2) @(negedge clk);
        r_n = 1'b1;

        // Complemented 0x06: bits 0,1,0,1,1,1,1,1 -> 0xFA
        send_word(8'hFA, 1'b0, 1'b0);
        chk("t1_valid", 32'(p_valid), 32'd1);
        chk("t1_data", 32'(p_data), 32'hFA);
        chk("t1_ovf", 32'(ovf), 32'd0);

        // Back-to-back frames with a ready consumer
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'hFA, 1'b1, 1'b1);
        chk("t2_first", 32'(p_data), 32'hFA);
        send_word(8'h01, 1'b1, 1'b1);
        chk("t2_second", 32'(p_data), 32'h01);
        chk("t2_valid", 32'(p_valid), 32'd1);

        // Overrun: consumer stalled across two completions
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'hFA, 1'b0, 1'b0);
        send_word(8'h33, 1'b0, 1'b0);
        chk("t3_held", 32'(p_data), 32'hFA);
        chk("t3_ovf", 32'(ovf), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_drained", 32'(p_valid), 32'd0);
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);

        // Completion on the same edge as the drain
        async_reset("t4_rst");
        send_word(8'h3C, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1);
        chk("t4_valid", 32'(p_valid), 32'd1);
        chk("t4_data", 32'(p_data), 32'hC3);
        chk("t4_ovf", 32'(ovf), 32'd0);

        // Restart after 5 bits
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cyc(1'b1, k == 0, 1'b1, 1'b1);
        w = 8'hA5;
        for (int k = 0; k < WIDTH; k++) begin
            cyc(1'b1, k == 0, w[k], 1'b0);
            if (k == 0) begin
                chk("t5_ferr", 32'(ferr), 32'd1);
                chk("t5_busy", 32'(busy), 32'd1);
            end
            if (k == 1) chk("t5_ferr_end", 32'(ferr), 32'd0);
        end
        chk("t5_data", 32'(p_data), 32'hA5);

        // Reset while a word is held, then mid-frame at bit 4
        async_reset("t6_rst_valid");
        w = 8'h96;
        for (int k = 0; k < 4; k++) cyc(1'b1, k == 0, w[k], 1'b1);
        async_reset("t6_rst_mid");
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t6_ignored", 32'(p_valid), 32'd0);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("t6_data", 32'(p_data), 32'h5A);

        // Randomized traffic with occasional resets
        for (int blk = 0; blk < 6; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 100);
            for (int i = 0; i < 500; i++) begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                    1'($urandom_range(0, 1)), $urandom_range(1, 100) <= rdy_pct);
            end
            async_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
